nonce_sweep_ctrl: RTL

//  Initiator for bitcoin_double_sha256: accepts a mining job (76-byte header prefix, nonce range, target).

---
 rtl/nonce_sweep_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: walks a nonce range through one double-SHA256 core,
// compares each result against the job target and reports winners over valid/ready.
module nonce_sweep_ctrl #(
    parameter int STOP_ON_FIND = 1,
    parameter int HASH_REV     = 1,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [607:0] job_header,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    input  logic         abort,
    output logic         core_start,
    output logic [639:0] core_header,
    input  logic [255:0] core_hash,
    input  logic         core_done,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         busy,
    output logic         exhausted,
    output logic         err_timeout
);
    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_REPORT, S_DONE, S_DRAIN
    } state_t;

    state_t           state_reg, state_next;
    logic [607:0]     hdr_reg;
    logic [31:0]      nonce_reg, nonce_next;
    logic [31:0]      end_reg;
    logic [255:0]     target_reg;
    logic [255:0]     hash_reg;
    logic [255:0]     cmp_hash;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic             exh_reg, exh_next;
    logic             ready_en_reg;
    logic             accept, win, last_nonce, timeout_hit;

    // Bitcoin compares the digest as a little-endian number, hence the optional byte swap.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cmp
            if (HASH_REV != 0) begin : g_swap
                assign cmp_hash[8*gi +: 8] = hash_reg[8*(31-gi) +: 8];
            end else begin : g_keep
                assign cmp_hash[8*gi +: 8] = hash_reg[8*gi +: 8];
            end
        end
    endgenerate

    assign accept      = job_valid && job_ready;
    assign win         = (cmp_hash <= target_reg);
    assign last_nonce  = (nonce_reg == end_reg);
    assign timeout_hit = (cnt_reg == CNT_W'(DONE_TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        nonce_next = nonce_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        exh_next   = exh_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    nonce_next = nonce_start;
                    err_next   = 1'b0;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next   = CNT_W'(1);
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // An aborted request still owns the core until it answers or times out.
                if (abort) begin
                    state_next = (core_done || timeout_hit) ? S_IDLE : S_DRAIN;
                end else if (core_done) begin
                    state_next = S_CHECK;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    exh_next   = 1'b0;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (win) begin
                    state_next = S_REPORT;
                end else if (last_nonce) begin
                    exh_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    nonce_next = nonce_reg + 32'd1;
                    state_next = S_ISSUE;
                end
            end
            S_REPORT: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (found_ready) begin
                    if (STOP_ON_FIND != 0) begin
                        exh_next   = 1'b0;
                        state_next = S_DONE;
                    end else if (last_nonce) begin
                        exh_next   = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        nonce_next = nonce_reg + 32'd1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (core_done || timeout_hit) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            hdr_reg      <= '0;
            nonce_reg    <= '0;
            end_reg      <= '0;
            target_reg   <= '0;
            hash_reg     <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
            exh_reg      <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            nonce_reg    <= nonce_next;
            cnt_reg      <= cnt_next;
            err_reg      <= err_next;
            exh_reg      <= exh_next;
            ready_en_reg <= 1'b1;
            if (accept) begin
                hdr_reg    <= job_header;
                end_reg    <= nonce_end;
                target_reg <= target;
            end
            if (state_reg == S_WAIT && core_done) begin
                hash_reg <= core_hash;
            end
        end
    end

    // job_ready waits one edge after reset release so it is never high while in reset.
    assign job_ready   = (state_reg == S_IDLE) && ready_en_reg;
    assign core_start  = (state_reg == S_ISSUE) && !abort;
    assign core_header = {hdr_reg, nonce_reg};
    assign found_valid = (state_reg == S_REPORT);
    assign found_nonce = nonce_reg;
    assign found_hash  = hash_reg;
    assign busy        = (state_reg != S_IDLE);
    assign exhausted   = (state_reg == S_DONE) && exh_reg;
    assign err_timeout = err_reg;
endmodule
